// File: rtl/cpu_clk_gen_pkg.sv
// Shared types and default sizing for the CPU clock generator.
package cpu_clk_pkg;

    localparam int DEF_DIV_W        = 16;
    localparam int DEF_DEFAULT_HALF = 4;
    localparam int DEF_STEP_W       = 8;
    localparam int DEF_CNT_W        = 32;

    // Generator mode: halted, free-running, or running out a step burst.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } clk_state_e;

endpackage : cpu_clk_pkg

// File: rtl/cpu_clk_gen_if.sv
// Control/status bundle between the clock generator and its controller.
interface cpu_clk_gen_if
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int STEP_W = DEF_STEP_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              cfg_we;
    logic [DIV_W-1:0]  half_period;
    logic              run;
    logic              step;
    logic [STEP_W-1:0] step_count;
    logic              sub_clk;
    logic              sub_rise;
    logic              sub_fall;
    logic              busy;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output cfg_we, half_period, run, step, step_count,
        input  sub_clk, sub_rise, sub_fall, busy, cycle_count
    );

    modport slave (
        input  cfg_we, half_period, run, step, step_count,
        output sub_clk, sub_rise, sub_fall, busy, cycle_count
    );
endinterface : cpu_clk_gen_if

// File: rtl/cpu_clk_gen_half_period_timer.sv
// Counts mclk cycles within one sub_clk phase and flags the last cycle.
module half_period_timer
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [DIV_W-1:0] active_half_i,
    output logic             expire_o
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             hit_s;

    // active_half is never 0, so the subtraction cannot underflow.
    assign hit_s    = (cnt_q == (active_half_i - DIV_W'(1)));
    assign expire_o = enable_i && hit_s;

    // Next count: restart on clear or expiry, advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (hit_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Phase counter register.
    always_ff @(posedge mclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule : half_period_timer

// File: rtl/cpu_clk_gen.sv
// Programmable-divide CPU clock with run / halt / step-burst control.
module cpu_clk_gen
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W        = DEF_DIV_W,
    parameter int DEFAULT_HALF = DEF_DEFAULT_HALF,
    parameter int STEP_W       = DEF_STEP_W,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic          mclk,
    input  logic          reset,
    cpu_clk_gen_if.slave  bus
);
    clk_state_e        state_q;
    logic [DIV_W-1:0]  pending_half_q;
    logic [DIV_W-1:0]  active_half_q;
    logic [STEP_W-1:0] remaining_q;
    logic [CNT_W-1:0]  cycle_count_q;
    logic              sub_clk_q;
    logic              sub_rise_q;
    logic              sub_fall_q;
    logic              expire_s;
    logic              idle_s;

    assign idle_s = (state_q == IDLE);

    half_period_timer #(.DIV_W(DIV_W)) u_timer (
        .mclk          (mclk),
        .reset         (reset),
        .enable_i      (!idle_s),
        .clear_i       (idle_s),
        .active_half_i (active_half_q),
        .expire_o      (expire_s)
    );

    // Mode FSM, config registers, edge strobes and rise counter. Every
    // sub_clk transition (and leaving IDLE) latches the pending half-period,
    // so a reconfiguration only ever takes effect at a phase boundary.
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q        <= IDLE;
            pending_half_q <= DIV_W'(DEFAULT_HALF);
            active_half_q  <= DIV_W'(DEFAULT_HALF);
            remaining_q    <= '0;
            cycle_count_q  <= '0;
            sub_clk_q      <= 1'b0;
            sub_rise_q     <= 1'b0;
            sub_fall_q     <= 1'b0;
        end else begin
            sub_rise_q <= 1'b0;
            sub_fall_q <= 1'b0;
            if (bus.cfg_we) begin
                pending_half_q <= (bus.half_period == '0) ? DIV_W'(1) : bus.half_period;
            end else begin
                pending_half_q <= pending_half_q;
            end
            case (state_q)
                IDLE: begin
                    if (bus.run) begin
                        state_q       <= RUN;
                        active_half_q <= pending_half_q;
                        sub_clk_q     <= 1'b1;
                        sub_rise_q    <= 1'b1;
                        cycle_count_q <= cycle_count_q + CNT_W'(1);
                    end else if (bus.step && (bus.step_count != '0)) begin
                        state_q       <= STEP;
                        remaining_q   <= bus.step_count - STEP_W'(1);
                        active_half_q <= pending_half_q;
                        sub_clk_q     <= 1'b1;
                        sub_rise_q    <= 1'b1;
                        cycle_count_q <= cycle_count_q + CNT_W'(1);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN, STEP: begin
                    if (expire_s) begin
                        active_half_q <= pending_half_q;
                        if (sub_clk_q) begin
                            sub_clk_q  <= 1'b0;
                            sub_fall_q <= 1'b1;
                        end else if ((state_q == RUN) ? bus.run : (remaining_q != '0)) begin
                            if (state_q == STEP) begin
                                remaining_q <= remaining_q - STEP_W'(1);
                            end else begin
                                remaining_q <= remaining_q;
                            end
                            sub_clk_q     <= 1'b1;
                            sub_rise_q    <= 1'b1;
                            cycle_count_q <= cycle_count_q + CNT_W'(1);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    sub_clk_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sub_clk     = sub_clk_q;
    assign bus.sub_rise    = sub_rise_q;
    assign bus.sub_fall    = sub_fall_q;
    assign bus.busy        = !idle_s;
    assign bus.cycle_count = cycle_count_q;
endmodule : cpu_clk_gen
